mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data port (port B) of the 32K x 16 dual-port program/data memory between two
//  requesters: req 0 = CPU load/store unit, req 1 = peripheral/DMA reader (e.g. display fetch).
//  Fixed priority to req 0, with a starvation guard for req 1. Returns read data with the memory's
//  1-cycle registered latency, tagged by a per-requester valid pulse. Port A (instruction fetch) is untouched.
// PARAMETERS
//  ADDR_W        15  memory word-address width
//  DATA_W        16  memory word width
//  STARVE_LIMIT  4   max consecutive cycles req 1 may wait while req 0 wins; range 1..15
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  req0/req1  in   1       access request; held with addr/we/wdata until matching gnt
//  we0/we1    in   1       1 = write, 0 = read
//  addr0/1    in   ADDR_W  word address
//  wdata0/1   in   DATA_W  write data
//  gnt0/gnt1  out  1       combinational; access issued to memory this cycle
//  rvalid0/1  out  1       registered; rdata holds read result for that requester this cycle
//  rdata      out  DATA_W  = mem_dout (pass-through, shared)
//  mem_addr   out  ADDR_W  to memory port B address
//  mem_din    out  DATA_W  to memory port B write data
//  mem_we     out  1       to memory port B write enable
//  mem_dout   in   DATA_W  from memory port B registered output
// BEHAVIOUR
//  - Reset: gnt0/1=0, rvalid0/1=0, mem_we=0, starve_cnt=0; while reset=1 no grant is issued and
//    mem_we is forced 0. A read granted the cycle before reset asserts produces no rvalid.
//  - Arbitration (same cycle, combinational): at most one gnt per cycle.
//    starved = (starve_cnt >= STARVE_LIMIT).
//    req1 & (starved | ~req0) -> gnt1; else req0 -> gnt0; else none.
//  - starve_cnt (4 bits, registered): +1 when req1 & ~gnt1; cleared on gnt1 or when req1=0;
//    saturates at 15, never wraps.
//  - Mux: mem_addr/mem_din/mem_we follow the granted requester. With no grant, mem_we=0 and
//    mem_addr/mem_din hold requester 0's values (no side effect).
//  - Latency: read granted in cycle t -> rvalidN=1 in t+1 only, rdata=memory word. Writes never
//    raise rvalid; the write-first echo on mem_dout is ignored.
//  - Back-to-back: a requester may receive a grant every cycle; pipelined reads give consecutive
//    rvalid pulses, in order. Requester may change addr on the cycle after gnt.
//  - Dropping req before gnt is legal (request withdrawn, nothing issued).
//  - Same address from both requesters: serialized by grant order; a write granted at t is visible
//    to a read granted at t+1.
//  - Internal states: 2 registered bits (rd_pend0, rd_pend1) = one-hot "read issued last cycle";
//    never both set.
// STRUCTURE
//  - Shared package (mem_pkg): MEM_ADDR_W=15, MEM_DATA_W=16, REQ_CPU=0, REQ_DMA=1.
//  - One sub-module: mem_arb_starve_ctr (saturating wait counter + starved compare); remainder
//    (priority logic, mux, rd_pend regs) inline.
// TESTING
//  1 Reset: hold reset 3 cycles with req0=req1=1, we0=1 -> gnt0=gnt1=0, mem_we=0 all cycles, rvalid=0.
//  2 Single read: mem[0x0010]=0x1234; req0, we0=0, addr0=0x0010 at t -> gnt0 at t, rvalid0 at t+1,
//    rdata=0x1234; rvalid1=0.
//  3 Write then read: req1 write 0xBEEF @0x7FFF at t, read 0x7FFF at t+1 -> no rvalid at t+1,
//    rvalid1 at t+2 with rdata=0xBEEF.
//  4 Starvation: req0 and req1 held continuously, STARVE_LIMIT=4 -> gnt0 for 4 cycles, gnt1 in 5th,
//    then gnt0 x4 again; starve_cnt returns to 0 after gnt1.
//  5 Contention only on req0 absent: req1 alone for 8 cycles -> gnt1 every cycle, 8 rvalid1 pulses
//    in order, addresses 0..7 returning preloaded 0xA000..0xA007.
//  6 Reset mid-read: read granted at t, reset=1 at t+1 -> rvalid0=0 at t+1 and t+2, no grants
//    while reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the port-B memory arbiter slice.
//   MEM_ADDR_W / MEM_DATA_W : geometry of the 32K x 16 program/data memory
//   REQ_CPU / REQ_DMA       : requester indices into the internal grant/pending vectors
//   STARVE_CNT_W / _MAX     : width and saturation value of the DMA wait counter
package mem_pkg;
  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 16;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  localparam int                STARVE_CNT_W   = 4;
  localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating wait counter for the low-priority requester.
// Counts consecutive cycles the requester is asking but not granted; clears
// on a grant or when the request is withdrawn; sticks at its maximum.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   req, gnt   : request and grant of the guarded requester
//   starved    : count has reached STARVE_LIMIT (from registered count, no loop)
module mem_arb_starve_ctr
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != STARVE_CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing memory port B between the CPU load/store unit (req 0) and
// a DMA/peripheral reader (req 1). Fixed priority to req 0, except that req 1
// wins once it has waited STARVE_LIMIT consecutive cycles. Read data comes back
// one cycle after the grant with a per-requester valid pulse.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   req0/1, we0/1         : request (held until grant), write enable
//   addr0/1, wdata0/1     : word address, write data
//   gnt0/1                : combinational grant, access issued this cycle
//   rvalid0/1             : rdata carries this requester's read result
//   rdata                 : pass-through of mem_dout
//   mem_addr/din/we       : drive memory port B
//   mem_dout              : memory port B registered read data
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  logic       starved;
  logic [1:0] gnt;
  logic [1:0] rd_pend;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .req    (req1),
    .gnt    (gnt[REQ_DMA]),
    .starved(starved)
  );

  // DMA wins when starved or when the CPU is idle; grants are suppressed
  // during reset so nothing reaches the memory.
  assign gnt[REQ_DMA] = !reset && req1 && (starved || !req0);
  assign gnt[REQ_CPU] = !reset && req0 && !gnt[REQ_DMA];

  assign gnt0 = gnt[REQ_CPU];
  assign gnt1 = gnt[REQ_DMA];

  // Idle cycles present requester 0's address/data with the write disabled.
  assign mem_addr = gnt[REQ_DMA] ? addr1  : addr0;
  assign mem_din  = gnt[REQ_DMA] ? wdata1 : wdata0;
  assign mem_we   = (gnt[REQ_CPU] && we0) || (gnt[REQ_DMA] && we1);

  // One-hot record of which requester issued a read last cycle; writes never
  // set it, so the memory's write-first echo is never reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= '0;
    end else begin
      rd_pend[REQ_CPU] <= gnt[REQ_CPU] && !we0;
      rd_pend[REQ_DMA] <= gnt[REQ_DMA] && !we1;
    end
  end

  // NOTE: the valid is masked by reset as well as cleared by it, so a read
  // granted in the cycle just before reset rises never reports data.
  assign rvalid0 = rd_pend[REQ_CPU] && !reset;
  assign rvalid1 = rd_pend[REQ_DMA] && !reset;
  assign rdata   = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected read
// returns, a monitor pops and compares whenever an rvalid is presented.
module tb_mem_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Port-B memory: registered output, write-first; preloaded in the same process.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    mem[15'h0010] = 16'h1234;
    mem[15'h0020] = 16'h5555;
    mem[15'h0030] = 16'h6666;
    mem[15'h7FFF] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[mem_addr] <= mem_din;
        mem_dout      <= mem_din;
      end else begin
        mem_dout <= mem[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented rvalid must match the oldest expected return.
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("rvalid_unexpected", {rvalid1, rvalid0}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rvalid_onehot", rvalid0 & rvalid1, 32'd0);
          check("rvalid_id", rvalid1, mon_e.id);
          check("rdata", rdata, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // One cycle: check combinational grant/mux outputs mid-cycle, then advance.
  task automatic step(input string tag, input logic eg0, input logic eg1,
                      input logic ewe, input logic [AW-1:0] ea);
    @(negedge clk);
    check({tag, "_gnt0"}, gnt0, eg0);
    check({tag, "_gnt1"}, gnt1, eg1);
    check({tag, "_mem_we"}, mem_we, ewe);
    if (eg0 || eg1) check({tag, "_mem_addr"}, mem_addr, ea);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    // 1: reset holds off all grants and writes even with both requesting.
    drive(1'b1, 1'b1, 15'h0005, 16'hDEAD, 1'b1, 1'b0, 15'h0006, 16'h0000);
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, '0);

    // 2: single CPU read.
    drive(1'b1, 1'b0, 15'h0010, '0, 1'b0, 1'b0, '0, '0);
    sb_q.push_back('{id: 1'b0, data: 16'h1234});
    step("rd0", 1'b1, 1'b0, 1'b0, 15'h0010);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step("rd0_idle", 1'b0, 1'b0, 1'b0, '0);

    // 3: DMA write then read-back of the top address.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 15'h7FFF, 16'hBEEF);
    step("wr1", 1'b0, 1'b1, 1'b1, 15'h7FFF);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'h7FFF, '0);
    sb_q.push_back('{id: 1'b1, data: 16'hBEEF});
    step("rd1_after_wr", 1'b0, 1'b1, 1'b0, 15'h7FFF);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step("wr_rd_idle", 1'b0, 1'b0, 1'b0, '0);

    // 4: continuous contention: CPU x4, DMA, CPU x4, DMA.
    drive(1'b1, 1'b0, 15'h0020, '0, 1'b1, 1'b0, 15'h0030, '0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        sb_q.push_back('{id: 1'b1, data: 16'h6666});
        step("starve_dma", 1'b0, 1'b1, 1'b0, 15'h0030);
      end else begin
        sb_q.push_back('{id: 1'b0, data: 16'h5555});
        step("starve_cpu", 1'b1, 1'b0, 1'b0, 15'h0020);
      end
      if (i == 4) check("starve_cnt_clear", dut.u_starve.cnt, 32'd0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step("starve_idle", 1'b0, 1'b0, 1'b0, '0);

    // 5: DMA alone, pipelined reads of 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      sb_q.push_back('{id: 1'b1, data: 16'hA000 + 16'(i)});
      step("burst1", 1'b0, 1'b1, 1'b0, AW'(i));
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step("burst_idle", 1'b0, 1'b0, 1'b0, '0);

    // 6: reset right after a granted read swallows the return.
    drive(1'b1, 1'b0, 15'h0010, '0, 1'b0, 1'b0, '0, '0);
    step("rd_before_rst", 1'b1, 1'b0, 1'b0, 15'h0010);
    reset = 1'b1;
    drive(1'b1, 1'b1, 15'h0011, 16'h0BAD, 1'b1, 1'b0, 15'h0012, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_rvalid0", rvalid0, 32'd0);
      check("rst_mid_gnt0", gnt0, 32'd0);
      check("rst_mid_gnt1", gnt1, 32'd0);
      check("rst_mid_mem_we", mem_we, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step("post_rst", 1'b0, 1'b0, 1'b0, '0);
    step("post_rst", 1'b0, 1'b0, 1'b0, '0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
